// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner and its debouncer.
package keypad_pkg;

  localparam int NROW = 4;
  localparam int NCOL = 4;

  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} deb_state_t;

  typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_res_t;

  // Number of asserted bits in one row's column sample (0..4).
  function automatic logic [2:0] count_pressed(input logic [NCOL-1:0] p);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NCOL; i++) begin
      n = n + {2'b00, p[i]};
    end
    return n;
  endfunction

  // Index of the lowest asserted bit; 0 when nothing is asserted.
  function automatic logic [1:0] low_index(input logic [NCOL-1:0] p);
    logic [1:0] idx;
    idx = '0;
    for (int i = NCOL - 1; i >= 0; i--) begin
      if (p[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_deb.sv
// Frame-level debouncer: accepts a key after DEB_CNT identical single frames
// and re-arms only after DEB_CNT consecutive empty frames.
module keypad_deb
  import keypad_pkg::*;
#(
  parameter int DEB_CNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_done,
  input  frame_res_t result,
  input  logic [3:0] code,
  output logic       accept,
  output logic [3:0] acc_code
);

  localparam logic [3:0] DEB = 4'(DEB_CNT);

  deb_state_t state, state_n;
  logic [3:0] cand, cand_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] cnt_inc;

  assign cnt_inc = cnt + 4'd1;

  // State, candidate and run-length registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cand  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
    end
  end

  // Next state and accept strobe; only frame_done cycles can change anything.
  always_comb begin
    state_n  = state;
    cand_n   = cand;
    cnt_n    = cnt;
    accept   = 1'b0;
    acc_code = cand;
    if (frame_done) begin
      unique case (state)
        IDLE: begin
          if (result == SINGLE) begin
            cand_n = code;
            cnt_n  = 4'd1;
            if (DEB == 4'd1) begin
              accept   = 1'b1;
              acc_code = code;
              state_n  = HELD;
            end else begin
              state_n = PRESS;
            end
          end
        end
        PRESS: begin
          if (result == SINGLE && code == cand) begin
            cnt_n = cnt_inc;
            if (cnt_inc == DEB) begin
              accept  = 1'b1;
              state_n = HELD;
            end
          end else begin
            cnt_n   = '0;
            state_n = IDLE;
          end
        end
        HELD: begin
          // A held key never repeats; a multi frame does not count as release.
          if (result == NONE) begin
            cnt_n   = 4'd1;
            state_n = (DEB == 4'd1) ? IDLE : RELEASE;
          end
        end
        RELEASE: begin
          if (result == NONE) begin
            cnt_n = cnt_inc;
            if (cnt_inc == DEB) state_n = IDLE;
          end else begin
            state_n = HELD;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 hex keypad scanner: drives rows, samples synchronized columns, builds a
// per-frame result, debounces it and shifts accepted digits into value.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DEB_CNT  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCOL-1:0] col,
  output logic [NROW-1:0] row,
  output logic            key_valid,
  output logic [3:0]      key_code,
  output logic [31:0]     value
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [NCOL-1:0] col_meta, col_s;
  logic [DIV_W-1:0] dwell;
  logic [1:0]       ridx;
  logic             sample;
  logic [NCOL-1:0]  pressed;
  logic [2:0]       npress;
  logic [1:0]       cidx;
  logic [1:0]       hits, hits_n;
  logic [3:0]       fcode, fcode_n;
  frame_res_t       result, result_n;
  logic [3:0]       res_code;
  logic             frame_done;
  logic             accept;
  logic [3:0]       acc_code;

  assign row     = ~(4'b0001 << ridx);
  assign sample  = (dwell == DIV_W'(SCAN_DIV - 1));
  assign pressed = ~col_s;
  assign npress  = count_pressed(pressed);
  assign cidx    = low_index(pressed);

  // Two-flop synchronizer for the asynchronous column inputs.
  always_ff @(posedge clk) begin
    col_meta <= col;
    col_s    <= col_meta;
  end

  // Fold the current row's sample into the frame accumulator (hits saturates at 2 = multi).
  always_comb begin
    hits_n  = hits;
    fcode_n = fcode;
    if (npress >= 3'd2) begin
      hits_n = 2'd2;
    end else if (npress == 3'd1) begin
      if (hits == 2'd0) begin
        hits_n  = 2'd1;
        fcode_n = {ridx, cidx};
      end else begin
        hits_n = 2'd2;
      end
    end
    unique case (hits_n)
      2'd0:    result_n = NONE;
      2'd1:    result_n = SINGLE;
      default: result_n = MULTI;
    endcase
  end

  // Dwell counter, row index, frame accumulator and end-of-frame strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dwell      <= '0;
      ridx       <= '0;
      hits       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (sample) begin
        dwell <= '0;
        ridx  <= ridx + 2'd1;
        if (ridx == 2'd3) begin
          frame_done <= 1'b1;
          hits       <= '0;
        end else begin
          hits <= hits_n;
        end
      end else begin
        dwell <= dwell + DIV_W'(1);
      end
    end
  end

  // Frame payload: first-seen code mid-frame, final result at the row-3 sample.
  always_ff @(posedge clk) begin
    if (sample) fcode <= fcode_n;
    if (sample && ridx == 2'd3) begin
      result   <= result_n;
      res_code <= fcode_n;
    end
  end

  keypad_deb #(.DEB_CNT(DEB_CNT)) u_deb (
    .clk        (clk),
    .rst        (rst),
    .frame_done (frame_done),
    .result     (result),
    .code       (res_code),
    .accept     (accept),
    .acc_code   (acc_code)
  );

  // Register the accept: one-cycle pulse, held code, digit shifted in at the bottom.
  always_ff @(posedge clk) begin
    if (!rst) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      value     <= '0;
    end else begin
      key_valid <= accept;
      if (accept) begin
        key_code <= acc_code;
        value    <= {value[27:0], acc_code};
      end
    end
  end

endmodule
